// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and shared types.
// Defaults for the raster generator and its sync windows.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF
                               + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF
                               + V_SYNC_DEF + V_BACK_DEF;

  localparam int HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the drawing stages.
// master drives coordinates and syncs; slave consumes them.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   hs;
  logic   vs;
  logic   frame_start;
  logic   line_start;
  logic   hs_d;
  logic   vs_d;
  logic   blank_d;

  modport master (
    output DrawX, DrawY, blank, hs, vs,
    output frame_start, line_start,
    output hs_d, vs_d, blank_d
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs,
    input frame_start, line_start,
    input hs_d, vs_d, blank_d
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Resettable shift register used to re-time sync/blank.
// DEPTH of zero degenerates to a plain wire.
module vga_sync_delay #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++)
            sr[i] <= RST_VAL;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with registered visible/sync/strobe flags.
// Sync and blank also leave through a delay line for the pixel pipe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_DELAY = 2
) (
  input  logic vga_clk,
  input  logic reset,
  vga_timing_gen_if.master vga
);

  localparam coord_t X_LAST =
    coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t Y_LAST =
    coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t X_VIS = coord_t'(H_VISIBLE);
  localparam coord_t Y_VIS = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI =
    coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI =
    coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t x, y, x_nxt, y_nxt;
  logic   blank, hs, vs, fs, ls;
  logic [2:0] dly;

  always_comb begin
    x_nxt = x + 10'd1;
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y == Y_LAST) ? '0 : y + 10'd1;
    end
  end

  // Flags come from the next count so they line up with it.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x     <= X_LAST;
      y     <= Y_LAST;
      blank <= 1'b0;
      hs    <= 1'b1;
      vs    <= 1'b1;
      fs    <= 1'b0;
      ls    <= 1'b0;
    end else begin
      x     <= x_nxt;
      y     <= y_nxt;
      blank <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
      hs    <= !((x_nxt >= HS_LO) && (x_nxt <= HS_HI));
      vs    <= !((y_nxt >= VS_LO) && (y_nxt <= VS_HI));
      fs    <= (x_nxt == '0) && (y_nxt == '0);
      ls    <= (x_nxt == '0);
    end
  end

  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (3'b110)
  ) u_dly (
    .clk  (vga_clk),
    .rst  (reset),
    .din  ({hs, vs, blank}),
    .dout (dly)
  );

  assign vga.DrawX       = x;
  assign vga.DrawY       = y;
  assign vga.blank       = blank;
  assign vga.hs          = hs;
  assign vga.vs          = vs;
  assign vga.frame_start = fs;
  assign vga.line_start  = ls;
  assign vga.hs_d        = dly[2];
  assign vga.vs_d        = dly[1];
  assign vga.blank_d     = dly[0];

endmodule
